sram_fifo_ctrl: RTL and testbench

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

---
 rtl/sram_fifo_pkg.sv | 15 +
 rtl/sram_rr_arb.sv | 28 ++
 rtl/sram_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_sram_fifo_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared types and constants for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

    localparam int DATA_W         = 16;
    localparam int DEPTH_LOG2_DEF = 20;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_SETUP  = 3'd1,
        ST_W_COMMIT = 3'd2,
        ST_R_ADDR   = 3'd3,
        ST_R_SAMPLE = 3'd4
    } state_e;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin arbiter: req[0]=write, req[1]=read, one-hot grant.
module sram_rr_arb (
    input  logic       gclk,
    input  logic       grst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Set when write wins a tie; starts out favouring write.
    logic pri_w;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || pri_w))
            gnt = 2'b01;
        else if (req[1])
            gnt = 2'b10;
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            pri_w <= 1'b1;
        else if (advance && (gnt != 2'b00))
            pri_w <= gnt[1];
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO built on an asynchronous single-port SRAM, one access every 3 cycles.
// Optional registered ALMOST_FULL flag under SRAM_FIFO_ALMOST_FULL_EN.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int AF_LEVEL   = 2**DEPTH_LOG2 - 1024
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST_B,
    input  logic                  CLEAR,
    input  logic                  WR_REQ,
    input  logic [DATA_W-1:0]     WR_DATA,
    output logic                  WR_ACK,
    input  logic                  RD_REQ,
    output logic [DATA_W-1:0]     RD_DATA,
    output logic                  RD_VALID,
    output logic [DEPTH_LOG2:0]   FIFO_SIZE,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic [DEPTH_LOG2-1:0] SRAM_A,
    inout  wire  [DATA_W-1:0]     SRAM_IO,
    output logic                  SRAM_WE_B,
    output logic                  SRAM_OE_B,
    output logic                  SRAM_CE1_B,
    output logic                  SRAM_BHE_B,
    output logic                  SRAM_BLE_B
);

    localparam logic [DEPTH_LOG2:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_e                state, state_nxt;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [1:0]            gnt;
    logic                  idle, wr_phase, rd_phase;

    assign EMPTY = (FIFO_SIZE == '0);
    assign FULL  = (FIFO_SIZE == CAP);
    assign idle  = (state == ST_IDLE);

    sram_rr_arb u_arb (
        .gclk    (BUS_CLK),
        .grst_n  (BUS_RST_B),
        .req     ({RD_REQ && !EMPTY, WR_REQ && !FULL}),
        .advance (idle && !CLEAR),
        .gnt     (gnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (gnt[0])      state_nxt = ST_W_SETUP;
                else if (gnt[1]) state_nxt = ST_R_ADDR;
            end
            ST_W_SETUP:  state_nxt = ST_W_COMMIT;
            ST_W_COMMIT: state_nxt = ST_IDLE;
            ST_R_ADDR:   state_nxt = ST_R_SAMPLE;
            ST_R_SAMPLE: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
        if (CLEAR)
            state_nxt = ST_IDLE;
    end

    // Only one of W_COMMIT / R_SAMPLE can be active, so FIFO_SIZE never moves both ways at once.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            FIFO_SIZE <= '0;
            RD_VALID  <= 1'b0;
            RD_DATA   <= '0;
        end else begin
            state    <= state_nxt;
            RD_VALID <= 1'b0;
            if (CLEAR) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                FIFO_SIZE <= '0;
            end else if (state == ST_W_COMMIT) begin
                wr_ptr    <= wr_ptr + 1'b1;
                FIFO_SIZE <= FIFO_SIZE + 1'b1;
            end else if (state == ST_R_SAMPLE) begin
                rd_ptr    <= rd_ptr + 1'b1;
                FIFO_SIZE <= FIFO_SIZE - 1'b1;
                RD_DATA   <= SRAM_IO;
                RD_VALID  <= 1'b1;
            end
        end
    end

    // SRAM strobes decode straight from state so an async reset releases the bus at once.
    assign wr_phase   = (state == ST_W_SETUP) || (state == ST_W_COMMIT);
    assign rd_phase   = (state == ST_R_ADDR) || (state == ST_R_SAMPLE);
    assign SRAM_A     = wr_phase ? wr_ptr : (rd_phase ? rd_ptr : '0);
    assign SRAM_CE1_B = !(wr_phase || rd_phase);
    assign SRAM_WE_B  = (state != ST_W_SETUP);
    assign SRAM_OE_B  = !rd_phase;
    assign SRAM_BHE_B = 1'b0;
    assign SRAM_BLE_B = 1'b0;
    assign SRAM_IO    = wr_phase ? WR_DATA : {DATA_W{1'bz}};
    assign WR_ACK     = (state == ST_W_COMMIT) && !CLEAR;

`ifdef SRAM_FIFO_ALMOST_FULL_EN
    localparam logic [DEPTH_LOG2:0] AF_LVL = (DEPTH_LOG2+1)'(AF_LEVEL);
    logic af_q;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B)
            af_q <= 1'b0;
        else
            af_q <= (FIFO_SIZE >= AF_LVL);
    end

    assign ALMOST_FULL = af_q;
`else
    assign ALMOST_FULL = 1'b0;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl (DEPTH_LOG2=4) with a behavioural SRAM model.
module tb_sram_fifo_ctrl;

    logic        BUS_CLK, BUS_RST_B, CLEAR, WR_REQ, RD_REQ;
    logic [15:0] WR_DATA, RD_DATA;
    logic        WR_ACK, RD_VALID, EMPTY, FULL, ALMOST_FULL;
    logic [4:0]  FIFO_SIZE;
    logic [3:0]  SRAM_A;
    wire  [15:0] SRAM_IO;
    logic        SRAM_WE_B, SRAM_OE_B, SRAM_CE1_B, SRAM_BHE_B, SRAM_BLE_B;

    int n_chk  = 0;
    int n_fail = 0;

    sram_fifo_ctrl #(.DEPTH_LOG2(4), .AF_LEVEL(12)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST_B(BUS_RST_B), .CLEAR(CLEAR),
        .WR_REQ(WR_REQ), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK),
        .RD_REQ(RD_REQ), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .FIFO_SIZE(FIFO_SIZE), .EMPTY(EMPTY), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL),
        .SRAM_A(SRAM_A), .SRAM_IO(SRAM_IO), .SRAM_WE_B(SRAM_WE_B), .SRAM_OE_B(SRAM_OE_B),
        .SRAM_CE1_B(SRAM_CE1_B), .SRAM_BHE_B(SRAM_BHE_B), .SRAM_BLE_B(SRAM_BLE_B)
    );

    // SRAM model: write latched while WE_B low at the clock edge, read driven while OE_B low.
    logic [15:0] mem [16];
    always @(posedge BUS_CLK)
        if (!SRAM_CE1_B && !SRAM_WE_B) mem[SRAM_A] <= SRAM_IO;
    assign SRAM_IO = (!SRAM_CE1_B && !SRAM_OE_B && SRAM_WE_B) ? mem[SRAM_A] : 16'hzzzz;

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] d, input string tag);
        bit got = 1'b0;
        WR_DATA = d;
        WR_REQ  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge BUS_CLK);
            if (WR_ACK) got = 1'b1;
        end
        WR_REQ = 1'b0;
        chk({tag, " ack"}, 32'(got), 32'd1);
        @(negedge BUS_CLK);
    endtask

    task automatic do_read(output logic [15:0] d, input string tag);
        bit got = 1'b0;
        d = 16'hDEAD;
        RD_REQ = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge BUS_CLK);
            if (RD_VALID) begin
                got = 1'b1;
                d   = RD_DATA;
            end
        end
        RD_REQ = 1'b0;
        chk({tag, " valid"}, 32'(got), 32'd1);
    endtask

    logic [15:0] rd;
    logic [3:0]  a_cap;
    logic [4:0]  sz [4];
    logic        typ_w [4];
    logic [15:0] rdat [4];
    int          ev, cnt;
    bit          pend, got;

    initial begin
        BUS_RST_B = 1'b0; CLEAR = 1'b0; WR_REQ = 1'b0; RD_REQ = 1'b0; WR_DATA = '0;
        repeat (2) @(negedge BUS_CLK);

        // Reset state
        chk("rst size",  32'(FIFO_SIZE), 32'd0);
        chk("rst empty", 32'(EMPTY), 32'd1);
        chk("rst full",  32'(FULL), 32'd0);
        chk("rst af",    32'(ALMOST_FULL), 32'd0);
        chk("rst strobes", {SRAM_WE_B, SRAM_OE_B, SRAM_CE1_B, SRAM_BHE_B, SRAM_BLE_B}, 32'b11100);
        chk("rst addr",  32'(SRAM_A), 32'd0);
        chk("rst ack/valid", {WR_ACK, RD_VALID}, 32'd0);
        chk("rst rd_data", 32'(RD_DATA), 32'd0);
        BUS_RST_B = 1'b1;
        @(negedge BUS_CLK);

        // Write 0x1234 with cycle-level bus checks, then 0xABCD, then read both back
        WR_DATA = 16'h1234; WR_REQ = 1'b1;
        @(negedge BUS_CLK);
        chk("wsetup strobes", {SRAM_WE_B, SRAM_CE1_B, SRAM_OE_B}, 32'b001);
        chk("wsetup addr", 32'(SRAM_A), 32'd0);
        chk("wsetup io", 32'(SRAM_IO), 32'h1234);
        chk("wsetup ack", 32'(WR_ACK), 32'd0);
        @(negedge BUS_CLK);
        chk("wcommit ack", 32'(WR_ACK), 32'd1);
        chk("wcommit we", 32'(SRAM_WE_B), 32'd1);
        WR_REQ = 1'b0;
        @(negedge BUS_CLK);
        chk("size after w1", 32'(FIFO_SIZE), 32'd1);
        do_write(16'hABCD, "w2");
        chk("size after w2", 32'(FIFO_SIZE), 32'd2);
        do_read(rd, "r1");
        chk("r1 data", 32'(rd), 32'h1234);
        chk("size after r1", 32'(FIFO_SIZE), 32'd1);
        do_read(rd, "r2");
        chk("r2 data", 32'(rd), 32'hABCD);
        chk("size after r2", 32'(FIFO_SIZE), 32'd0);
        chk("empty after r2", 32'(EMPTY), 32'd1);

        // Bring to 5 words with a read last, so a tie grants write first
        for (int i = 0; i < 6; i++) do_write(16'h0100 + 16'(i), "pre");
        do_read(rd, "pre r");
        chk("pre r data", 32'(rd), 32'h0100);
        chk("size 5", 32'(FIFO_SIZE), 32'd5);

        // Both requests held: expect W,R,W,R with size 6,5,6,5
        ev = 0; pend = 1'b0;
        WR_DATA = 16'h0200; WR_REQ = 1'b1; RD_REQ = 1'b1;
        for (int c = 0; c < 40 && ev < 4; c++) begin
            @(negedge BUS_CLK);
            if (pend) begin sz[ev-1] = FIFO_SIZE; pend = 1'b0; end
            if (WR_ACK) begin
                typ_w[ev] = 1'b1; rdat[ev] = 16'h0; ev++; pend = 1'b1;
                WR_DATA = WR_DATA + 16'h1;
            end else if (RD_VALID) begin
                typ_w[ev] = 1'b0; rdat[ev] = RD_DATA; ev++; pend = 1'b1;
            end
        end
        WR_REQ = 1'b0; RD_REQ = 1'b0;
        @(negedge BUS_CLK);
        if (pend) sz[ev-1] = FIFO_SIZE;
        chk("rr events", 32'(ev), 32'd4);
        chk("rr order", {typ_w[0], typ_w[1], typ_w[2], typ_w[3]}, 32'b1010);
        chk("rr sizes", {sz[0], sz[1], sz[2], sz[3]}, {5'd6, 5'd5, 5'd6, 5'd5});
        chk("rr rdata", {rdat[1], rdat[3]}, 32'h0101_0102);

        // Drain to 3, then CLEAR during W_SETUP
        do_read(rd, "d1");
        chk("d1 data", 32'(rd), 32'h0103);
        do_read(rd, "d2");
        chk("d2 data", 32'(rd), 32'h0104);
        chk("size 3", 32'(FIFO_SIZE), 32'd3);
        WR_DATA = 16'h5555; WR_REQ = 1'b1;
        @(negedge BUS_CLK);
        chk("clr in wsetup", 32'(SRAM_WE_B), 32'd0);
        CLEAR = 1'b1;
        @(negedge BUS_CLK);
        chk("clr ack", 32'(WR_ACK), 32'd0);
        chk("clr we/ce", {SRAM_WE_B, SRAM_CE1_B}, 32'b11);
        chk("clr size", 32'(FIFO_SIZE), 32'd0);
        chk("clr empty", 32'(EMPTY), 32'd1);
        // CLEAR held with a pending write must still block the grant
        @(negedge BUS_CLK);
        chk("clr blocks grant", {SRAM_WE_B, SRAM_CE1_B, WR_ACK}, 32'b110);
        CLEAR = 1'b0; WR_REQ = 1'b0;
        @(negedge BUS_CLK);

        // Fill to 16, 17th write stalls until one read, lands at address 0
        for (int i = 0; i < 16; i++) do_write(16'h0300 + 16'(i), "fill");
        chk("full size", 32'(FIFO_SIZE), 32'd16);
        chk("full flag", 32'(FULL), 32'd1);
`ifdef SRAM_FIFO_ALMOST_FULL_EN
        chk("af at full", 32'(ALMOST_FULL), 32'd1);
`else
        chk("af tied off", 32'(ALMOST_FULL), 32'd0);
`endif
        WR_DATA = 16'h03FF; WR_REQ = 1'b1; cnt = 0;
        repeat (6) begin
            @(negedge BUS_CLK);
            if (WR_ACK) cnt++;
        end
        chk("stall no ack", 32'(cnt), 32'd0);
        chk("stall size", 32'(FIFO_SIZE), 32'd16);
        do_read(rd, "unstall r");
        chk("unstall data", 32'(rd), 32'h0300);
        got = 1'b0; a_cap = 4'hF;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge BUS_CLK);
            if (!SRAM_WE_B) a_cap = SRAM_A;
            if (WR_ACK) got = 1'b1;
        end
        WR_REQ = 1'b0;
        chk("unstall ack", 32'(got), 32'd1);
        chk("wrap addr", 32'(a_cap), 32'd0);
        @(negedge BUS_CLK);
        chk("refull size", 32'(FIFO_SIZE), 32'd16);

        // Async reset during R_ADDR releases bus immediately
        RD_REQ = 1'b1;
        @(negedge BUS_CLK);
        chk("raddr strobes", {SRAM_OE_B, SRAM_CE1_B, SRAM_WE_B}, 32'b001);
        chk("raddr addr", 32'(SRAM_A), 32'd1);
        #2 BUS_RST_B = 1'b0;
        #1;
        chk("arst strobes", {SRAM_OE_B, SRAM_CE1_B}, 32'b11);
        chk("arst size", 32'(FIFO_SIZE), 32'd0);
        chk("arst addr", 32'(SRAM_A), 32'd0);
        RD_REQ = 1'b0;
        @(negedge BUS_CLK);
        BUS_RST_B = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge BUS_CLK);
            if (RD_VALID) cnt++;
        end
        chk("arst no valid", 32'(cnt), 32'd0);
        chk("arst empty", 32'(EMPTY), 32'd1);

`ifdef SRAM_FIFO_ALMOST_FULL_EN
        // ALMOST_FULL lags FIFO_SIZE by one cycle in both directions
        for (int i = 0; i < 12; i++) do_write(16'h0400 + 16'(i), "af fill");
        chk("af size 12", 32'(FIFO_SIZE), 32'd12);
        chk("af lag", 32'(ALMOST_FULL), 32'd0);
        @(negedge BUS_CLK);
        chk("af rise", 32'(ALMOST_FULL), 32'd1);
        do_read(rd, "af r");
        chk("af size 11", 32'(FIFO_SIZE), 32'd11);
        chk("af hold", 32'(ALMOST_FULL), 32'd1);
        @(negedge BUS_CLK);
        chk("af fall", 32'(ALMOST_FULL), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
